// File: rtl/add_result_fifo.sv
// add_result_fifo: captures each sum from the registered adder into a small
// first-word-fall-through FIFO. add_en is delayed one cycle (en_d) so that
// the write lines up with the sum appearing on add_s. A write that arrives
// while the FIFO is full, with no pop in the same cycle, is dropped and sets
// a sticky overflow flag.
// Optional feature: define ADD_RESULT_FIFO_DROP_CNT_EN to add a saturating
// 16-bit drop_cnt output that counts dropped writes.
module add_result_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       add_en,
  input  logic [WIDTH-1:0]           add_s,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  input  logic                       clr_ovf
`ifdef ADD_RESULT_FIFO_DROP_CNT_EN
  ,
  output logic [15:0]                drop_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic             en_d_q;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic wr_req, pop, wr_acc, drop;

  // handshake decode: a write may reuse the slot being popped in the same cycle
  always_comb begin
    wr_req = en_d_q;
    pop    = !empty && out_ready;
    wr_acc = wr_req && (!full || pop);
    drop   = wr_req && full && !pop;
  end

  // next-state for pointers, occupancy and the sticky overflow flag
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)    rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(wr_acc) - CW'(pop);
    // a new drop beats a clear in the same cycle
    if (drop)         ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
  end

  // control state, cleared asynchronously; a pending en_d write is discarded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_d_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      en_d_q   <= add_en;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // storage array; contents are don't-care after reset since count gates them
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= add_s;
  end

  // first-word-fall-through outputs
  always_comb begin
    empty     = (count_q == '0);
    full      = (count_q == CW'(DEPTH));
    out_valid = !empty;
    out_data  = empty ? '0 : mem_q[rd_ptr_q];
    count     = count_q;
    overflow  = ovf_q;
  end

`ifdef ADD_RESULT_FIFO_DROP_CNT_EN
  logic [15:0] dcnt_q, dcnt_d;

  // drop counter: clear wins over count, but a coincident drop loads 1
  always_comb begin
    dcnt_d = dcnt_q;
    if (clr_ovf)                      dcnt_d = drop ? 16'd1 : 16'd0;
    else if (drop && dcnt_q != 16'hFFFF) dcnt_d = dcnt_q + 16'd1;
  end

  // drop counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dcnt_q <= '0;
    else        dcnt_q <= dcnt_d;
  end

  assign drop_cnt = dcnt_q;
`endif

endmodule

// File: tb/tb_add_result_fifo.sv
// Bench for add_result_fifo: directed scenarios followed by random traffic,
// every cycle compared against a queue-based reference model.
module tb_add_result_fifo;
  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int PW    = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             add_en;
  logic [WIDTH-1:0] add_s;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [PW:0]      count;
  logic             full, empty, overflow;
  logic             clr_ovf;
`ifdef ADD_RESULT_FIFO_DROP_CNT_EN
  logic [15:0]      drop_cnt;
`endif

  add_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .add_en(add_en), .add_s(add_s),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .full(full), .empty(empty), .overflow(overflow),
    .clr_ovf(clr_ovf)
`ifdef ADD_RESULT_FIFO_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // reference model: queue of stored sums, pending-write flag, sticky flags
  int q[$];
  bit pend;
  bit m_ovf;
  int m_dcnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 32'(out_valid), 32'(q.size() > 0));
    chk({tag, ".data"},  32'(out_data),  q.size() > 0 ? 32'(q[0]) : 32'd0);
    chk({tag, ".count"}, 32'(count),     32'(q.size()));
    chk({tag, ".full"},  32'(full),      32'(q.size() == DEPTH));
    chk({tag, ".empty"}, 32'(empty),     32'(q.size() == 0));
    chk({tag, ".ovf"},   32'(overflow),  32'(m_ovf));
`ifdef ADD_RESULT_FIFO_DROP_CNT_EN
    chk({tag, ".dcnt"},  32'(drop_cnt),  32'(m_dcnt));
`endif
  endtask

  // one clock cycle: drive inputs, advance the model, sample after the edge
  task automatic step(input string tag, input bit en, input logic [15:0] s,
                      input bit rdy, input bit clr);
    bit pop, drop;
    add_en = en; add_s = s; out_ready = rdy; clr_ovf = clr;
    pop  = (q.size() > 0) && rdy;
    drop = 1'b0;
    if (pop) void'(q.pop_front());
    if (pend) begin
      if (q.size() < DEPTH) q.push_back(int'(s));
      else drop = 1'b1;
    end
    if (drop)     m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (clr)                          m_dcnt = drop ? 1 : 0;
    else if (drop && m_dcnt < 65535)  m_dcnt++;
    pend = en;
    @(posedge clk); #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0; add_en = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0; add_s = '0;
    #2;
    q.delete(); pend = 1'b0; m_ovf = 1'b0; m_dcnt = 0;
    check_all({tag, ".async"});
    @(posedge clk); #1;
    check_all({tag, ".held"});
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; add_en = 1'b0; add_s = '0; out_ready = 1'b0; clr_ovf = 1'b0;
    pend = 1'b0; m_ovf = 1'b0; m_dcnt = 0;
    #3;
    do_reset("rst0");

    // basic latency
    step("lat0", 1'b1, 16'h0000, 1'b0, 1'b0);
    chk("lat0.empty_still", 32'(empty), 32'd1);
    step("lat1", 1'b0, 16'h1234, 1'b0, 1'b0);
    chk("lat1.data_1234", 32'(out_data), 32'h1234);
    chk("lat1.count_1", 32'(count), 32'd1);
    step("lat2", 1'b0, 16'h0000, 1'b1, 1'b0);
    chk("lat2.empty", 32'(empty), 32'd1);

    // fill past capacity: sums 1..5, no reads
    for (int i = 0; i <= 5; i++)
      step("fill", i < 5, 16'(i), 1'b0, 1'b0);
    chk("fill.full", 32'(full), 32'd1);
    chk("fill.count4", 32'(count), 32'd4);
    chk("fill.ovf", 32'(overflow), 32'd1);
`ifdef ADD_RESULT_FIFO_DROP_CNT_EN
    chk("fill.dcnt1", 32'(drop_cnt), 32'd1);
`endif
    for (int i = 1; i <= 4; i++) begin
      chk("fill.order", 32'(out_data), 32'(i));
      step("drain", 1'b0, 16'h0, 1'b1, 1'b0);
    end

    // sticky clear with no drop
    step("clr", 1'b0, 16'h0, 1'b0, 1'b1);
    chk("clr.ovf0", 32'(overflow), 32'd0);

    // refill 1..4, then a drop coincident with clr_ovf
    for (int i = 0; i <= 5; i++)
      step("refill", i < 5, 16'(i), 1'b0, i == 5);
    chk("clrdrop.ovf1", 32'(overflow), 32'd1);
`ifdef ADD_RESULT_FIFO_DROP_CNT_EN
    chk("clrdrop.dcnt1", 32'(drop_cnt), 32'd1);
`endif
    step("clr2", 1'b0, 16'h0, 1'b0, 1'b1);

    // full write coincident with a pop
    step("fwp0", 1'b1, 16'h0, 1'b0, 1'b0);
    step("fwp1", 1'b0, 16'd9, 1'b1, 1'b0);
    chk("fwp.count4", 32'(count), 32'd4);
    chk("fwp.ovf0", 32'(overflow), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("fwp.order", 32'(out_data), (i < 3) ? 32'(i + 2) : 32'd9);
      step("fwp.pop", 1'b0, 16'h0, 1'b1, 1'b0);
    end

    // wrap-around: 100..109 streamed through with continuous reads
    for (int i = 0; i <= 11; i++)
      step("wrap", i < 10, (i > 0) ? 16'(99 + i) : 16'h0, 1'b1, 1'b0);
    chk("wrap.empty", 32'(empty), 32'd1);

    // reset mid-stream with three stored and a write pending
    for (int i = 0; i <= 3; i++)
      step("pre_rst", 1'b1, 16'(50 + i), 1'b0, 1'b0);
    chk("pre_rst.count3", 32'(count), 32'd3);
    do_reset("rst1");
    chk("rst1.count0", 32'(count), 32'd0);
    step("post0", 1'b0, 16'h77, 1'b0, 1'b0);
    chk("post0.empty", 32'(empty), 32'd1);
    step("post1", 1'b1, 16'h0, 1'b0, 1'b0);
    step("post2", 1'b0, 16'hBEEF, 1'b0, 1'b0);
    step("post3", 1'b0, 16'h0, 1'b0, 1'b0);
    chk("post.count1", 32'(count), 32'd1);
    chk("post.data", 32'(out_data), 32'hBEEF);

    // random traffic: alternate between fill-heavy and drain-heavy phases
    for (int i = 0; i < 600; i++) begin
      bit rdy;
      rdy = ((i / 100) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      step("rand", 1'($urandom_range(0, 1)), 16'($urandom), rdy,
           $urandom_range(0, 15) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/add_result_fifo.md
ADD_RESULT_FIFO -- requirements
Module: add_result_fifo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, the result word width, matching the adder sum width.
REQ-002 The block SHALL have parameter DEPTH, default 4, the number of FIFO entries; legal values are powers of two from 2 to 64.
REQ-003 The block SHALL have port clk, input, 1 bit, the rising-edge clock shared with the 16-bit registered adder.
REQ-004 The block SHALL have port rst_n, input, 1 bit, the reset: asynchronous, active-low.
REQ-005 The block SHALL have port add_en, input, 1 bit, a copy of the enable driven into the adder in the same cycle.
REQ-006 The block SHALL have port add_s, input, WIDTH bits, the adder's registered sum output S.
REQ-007 The block SHALL have port out_valid, output, 1 bit, which is high when a result is available at out_data.
REQ-008 The block SHALL have port out_ready, input, 1 bit, the consumer's acceptance strobe.
REQ-009 The block SHALL have port out_data, output, WIDTH bits, the oldest stored result.
REQ-010 The block SHALL have port count, output, log2(DEPTH)+1 bits, the number of stored entries.
REQ-011 The block SHALL have ports full and empty, outputs, 1 bit each, where full means count==DEPTH and empty means count==0.
REQ-012 The block SHALL have port overflow, output, 1 bit, a sticky flag that is set when a result is lost.
REQ-013 The block SHALL have port clr_ovf, input, 1 bit, a synchronous clear for overflow.

Function
REQ-014 The block SHALL register add_en into en_d on every clock edge, because add_s holds the new sum one cycle after add_en.
REQ-015 A write SHALL be requested in a cycle when en_d==1, with write data equal to add_s in that cycle.
REQ-016 A pop SHALL occur in a cycle when out_valid && out_ready, removing the entry at the read pointer.
REQ-017 A write SHALL be accepted when !full, or when full and a pop occurs in the same cycle.
REQ-018 A write request while full with no pop SHALL be dropped, SHALL leave contents unchanged, and SHALL set overflow on the next edge.
REQ-019 The block SHALL be first-word-fall-through: out_valid = !empty, and out_data = the entry at the read pointer when !empty, else 0.
REQ-020 Latency SHALL be as follows: with add_en high at edge N, the sum is on add_s after N; it is written at edge N+1; out_valid is high after N+1 if the FIFO was empty.
REQ-021 A simultaneous write and pop SHALL leave count unchanged; with the FIFO empty, only the write takes effect, because no pop is possible.
REQ-022 Read and write pointers SHALL be log2(DEPTH) bits and SHALL wrap from DEPTH-1 to 0 with no gap.
REQ-023 If clr_ovf and a new drop occur in the same cycle, set SHALL win and overflow stays 1.
REQ-024 Storage SHALL preserve arrival order; an entry SHALL NOT be modified between its write and its pop.
REQ-025 out_data and out_valid SHALL NOT change while out_valid && !out_ready, except through reset.

Reset
REQ-026 While rst_n==0, the block SHALL asynchronously force en_d=0, both pointers=0, count=0, overflow=0, out_valid=0, out_data=0, empty=1 and full=0.
REQ-027 Reset asserted mid-operation SHALL discard all stored entries and any pending en_d write; storage array contents need not be cleared.
REQ-028 After rst_n deasserts, the first add_en SHALL be tracked normally, with no spurious write.

Configuration
REQ-029 When macro ADD_RESULT_FIFO_DROP_CNT_EN is defined, the block SHALL add port drop_cnt, output, 16 bits, counting dropped writes.
REQ-030 drop_cnt SHALL saturate at 16'hFFFF, SHALL be cleared by reset and by clr_ovf, and on a simultaneous drop and clr_ovf SHALL load 1.
REQ-031 When ADD_RESULT_FIFO_DROP_CNT_EN is undefined, port drop_cnt and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-032 Basic latency: add_en pulse at edge 0 with add_s=16'h1234 at edge 1 -> out_valid high after edge 1, out_data=16'h1234, count=1; out_ready pulse -> empty=1.
REQ-033 Fill and overflow: DEPTH=4, five consecutive add_en cycles with sums 1..5, out_ready=0 -> full=1, count=4, overflow=1; pops yield 1,2,3,4; with macro, drop_cnt=1.
REQ-034 Full write plus pop: FIFO full with 1..4, en_d write of 9 coincident with a pop -> no overflow, count stays 4, read order 2,3,4,9.
REQ-035 Wrap-around: 10 write/pop pairs through DEPTH=4 with values 100..109 -> all values read in order, and empty=1 at the end.
REQ-036 Reset mid-stream: 3 entries stored and en_d=1 when rst_n pulses low -> count=0, out_valid=0, overflow=0; the next add_en yields exactly one entry.
REQ-037 Sticky clear: overflow=1, then clr_ovf=1 for one cycle with no drop -> overflow=0; clr_ovf coincident with a drop -> overflow remains 1.
